fir3_inverse: RTL and testbench

Sequential inverse (deconvolution) filter for the 3-tap FIR with coefficients 2, 3, 5, so that y[n] = 2·x[n] + 3·x[n−1] + 5·x[n−2]. It accepts 9-bit FIR output samples over a valid/ready handshake and recovers the 4-bit unsigned input samples using x[n] = (y[n] − B1·x[n−1] − B2·x[n−2]) / B0. It sits at the receive end of the filter datapath and can be used as a loopback checker.

---
 rtl/fir3_inverse.sv | 181 ++++++++++++++++++
 tb/tb_fir3_inverse.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir3_inverse.sv
// fir3_inverse
//   Sequential inverse of the 3-tap FIR y[n] = B0*x[n] + B1*x[n-1] + B2*x[n-2].
//   Recovers 4-bit unsigned x[n] from 9-bit y[n] using the two previously
//   recovered samples. Each sample passes through IDLE -> SUB -> DIV(4) -> OUT.
//
//   Build option: FIR3INV_ERRCHK_EN
//     defined   : err flags neg/overflow/inexact residuals, x_out = 0 on error
//                 and the history is cleared so decoding resynchronises.
//     undefined : err tied low, x_out saturates (0 / 15 / floor(r/B0)) and the
//                 history always shifts in x_out.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   y_in, in_valid      : FIR output sample in, valid
//   in_ready            : high only in IDLE
//   x_out, out_valid    : recovered sample (registered), valid
//   out_ready           : downstream accept
//   err                 : recovered sample inexact (qualified by out_valid)
module fir3_inverse #(
    parameter logic [3:0] B0 = 4'd2,
    parameter logic [3:0] B1 = 4'd3,
    parameter logic [3:0] B2 = 4'd5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] y_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] x_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err
);

    generate
        if (B0 == 4'd0) begin : g_bad_b0
            $error("fir3_inverse: B0 must be non-zero");
        end
    endgenerate

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUB  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    // Residuals at or above 16*B0 would need a fifth quotient bit.
    localparam logic [10:0] OVF_LIM = {3'b000, B0, 4'b0000};

    logic [1:0]  state_q, state_d;
    logic [8:0]  y_q, y_d;
    logic [7:0]  acc_q, acc_d;   // partial remainder
    logic [6:0]  dvs_q, dvs_d;   // B0 aligned to the current quotient bit
    logic [3:0]  quo_q, quo_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        ovf_q, ovf_d;
    logic [3:0]  xd1_q, xd1_d;
    logic [3:0]  xd2_q, xd2_d;
    logic [3:0]  x_q, x_d;
    logic        vld_q, vld_d;
    logic        err_q, err_d;
    logic [10:0] resid;
    logic        qbit;
`ifdef FIR3INV_ERRCHK_EN
    logic        bad;
`endif

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        xd1_d   = xd1_q;
        xd2_d   = xd2_q;
        x_d     = x_q;
        vld_d   = vld_q;
        err_d   = err_q;
        qbit    = 1'b0;
`ifdef FIR3INV_ERRCHK_EN
        bad     = 1'b0;
`endif
        // Two's-complement wrap in 11 bits gives the signed residual directly.
        resid = {2'b00, y_q} - 11'(B1) * 11'(xd1_q) - 11'(B2) * 11'(xd2_q);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    y_d     = y_in;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                neg_d   = resid[10];
                ovf_d   = !resid[10] && (resid >= OVF_LIM);
                acc_d   = resid[7:0];
                dvs_d   = {B0, 3'b000};
                quo_d   = 4'd0;
                cnt_d   = 2'd0;
                state_d = S_DIV;
            end
            S_DIV: begin
                if ({1'b0, dvs_q} <= acc_q) begin
                    acc_d = acc_q - {1'b0, dvs_q};
                    qbit  = 1'b1;
                end
                quo_d = {quo_q[2:0], qbit};
                dvs_d = dvs_q >> 1;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
`ifdef FIR3INV_ERRCHK_EN
                    bad   = neg_q | ovf_q | (acc_d != 8'd0);
                    x_d   = bad ? 4'd0 : quo_d;
                    err_d = bad;
                    if (bad) begin
                        xd1_d = 4'd0;
                        xd2_d = 4'd0;
                    end else begin
                        xd1_d = quo_d;
                        xd2_d = xd1_q;
                    end
`else
                    x_d   = neg_q ? 4'd0 : (ovf_q ? 4'd15 : quo_d);
                    err_d = 1'b0;
                    xd1_d = x_d;
                    xd2_d = xd1_q;
`endif
                    vld_d   = 1'b1;
                    state_d = S_OUT;
                end
            end
            default: begin  // S_OUT
                if (out_ready) begin
                    vld_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            y_q     <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            xd1_q   <= '0;
            xd2_q   <= '0;
            x_q     <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            xd1_q   <= xd1_d;
            xd2_q   <= xd2_d;
            x_q     <= x_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign x_out     = x_q;
    assign out_valid = vld_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fir3_inverse.sv
// Bench for fir3_inverse: spec vector table, hand-written corner sequences
// (odd / negative / overflow residuals, backpressure, reset mid-division)
// and a randomized run checked against an integer-arithmetic model.
module tb_fir3_inverse;

    localparam int B0 = 2;
    localparam int B1 = 3;
    localparam int B2 = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] y_in = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] x_out;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       err;

    int checks = 0;
    int errors = 0;
    int mh1 = 0, mh2 = 0;  // model history

    fir3_inverse #(.B0(4'd2), .B1(4'd3), .B2(4'd5)) dut (
        .clk(clk), .rst_n(rst_n), .y_in(y_in), .in_valid(in_valid),
        .in_ready(in_ready), .x_out(x_out), .out_valid(out_valid),
        .out_ready(out_ready), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int y;
        int x;
        int e;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer deconvolution step.
    task automatic model(input int y, output int x, output int e);
        int  r;
        bit  neg, ovf, odd;
        r   = y - B1 * mh1 - B2 * mh2;
        neg = (r < 0);
        ovf = (r >= 16 * B0);
        odd = !neg && ((r % B0) != 0);
`ifdef FIR3INV_ERRCHK_EN
        e = (neg || ovf || odd) ? 1 : 0;
        x = (e != 0) ? 0 : r / B0;
        if (e != 0) begin
            mh1 = 0;
            mh2 = 0;
        end else begin
            mh2 = mh1;
            mh1 = x;
        end
`else
        e = 0;
        x = neg ? 0 : (ovf ? 15 : r / B0);
        mh2 = mh1;
        mh1 = x;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        mh1 = 0;
        mh2 = 0;
        @(negedge clk);
        check("rst in_ready", int'(in_ready), 1);
        check("rst out_valid", int'(out_valid), 0);
        check("rst x_out", int'(x_out), 0);
        check("rst err", int'(err), 0);
        rst_n = 1'b1;
    endtask

    // Present one sample, wait for the result; completes the handshake
    // (and checks in_ready comes back) when out_ready is high.
    task automatic send(input int y, output int x, output int e);
        int lat;
        int wt;
        wt = 0;
        @(negedge clk);
        while (!in_ready && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        if (!in_ready) check("in_ready timeout", 0, 1);
        y_in = 9'(y);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 5);
        x = int'(x_out);
        e = int'(err);
        if (out_ready) begin
            @(posedge clk);
            #1;
            check("hs in_ready", int'(in_ready), 1);
            check("hs out_valid", int'(out_valid), 0);
        end
    endtask

    initial begin
        vec_t tbl[3];
        int   x, e, ex, ee, y;

        tbl[0] = '{y: 6,  x: 3, e: 0};
        tbl[1] = '{y: 23, x: 7, e: 0};
        tbl[2] = '{y: 38, x: 1, e: 0};

        rst_n = 1'b0;
        #12;
        do_reset();

        // Nominal table
        for (int i = 0; i < 3; i++) begin
            send(tbl[i].y, x, e);
            check("nominal x", x, tbl[i].x);
            check("nominal err", e, tbl[i].e);
        end

        // Odd residual
        do_reset();
        send(7, x, e);
`ifdef FIR3INV_ERRCHK_EN
        check("odd x", x, 0);
        check("odd err", e, 1);
        send(6, x, e);
        check("odd resync x", x, 3);
`else
        check("odd x", x, 3);
        check("odd err", e, 0);
`endif

        // Negative residual
        do_reset();
        send(6, x, e);
        check("neg pre x", x, 3);
        send(4, x, e);
        check("neg x", x, 0);
`ifdef FIR3INV_ERRCHK_EN
        check("neg err", e, 1);
        send(2, x, e);
        check("neg resync x", x, 1);
        check("neg resync err", e, 0);
`else
        check("neg err", e, 0);
`endif

        // Overflow
        do_reset();
        send(40, x, e);
`ifdef FIR3INV_ERRCHK_EN
        check("ovf x", x, 0);
        check("ovf err", e, 1);
`else
        check("ovf x", x, 15);
        check("ovf err", e, 0);
`endif

        // Backpressure with a stray in_valid
        do_reset();
        out_ready = 1'b0;
        send(6, x, e);
        check("bp x", x, 3);
        @(negedge clk);
        y_in = 9'd100;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp out_valid", int'(out_valid), 1);
            check("bp x_out", int'(x_out), 3);
            check("bp in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release in_ready", int'(in_ready), 1);
        check("bp release out_valid", int'(out_valid), 0);
        send(23, x, e);
        check("bp next x", x, 7);

        // Reset two cycles into DIV, with non-zero history beforehand
        do_reset();
        send(6, x, e);
        check("mid pre x", x, 3);
        @(negedge clk);
        y_in = 9'd23;
        in_valid = 1'b1;
        @(posedge clk);          // accept
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk); // SUB, DIV1, DIV2
        #1 rst_n = 1'b0;
        #1;
        check("mid out_valid", int'(out_valid), 0);
        check("mid in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        mh1 = 0;
        mh2 = 0;
        send(6, x, e);
        check("mid post x", x, 3);
        check("mid post err", e, 0);

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                y = B0 * int'($urandom_range(0, 15)) + B1 * mh1 + B2 * mh2;
                if (y > 511) y = 511;
            end else begin
                y = int'($urandom_range(0, 511));
            end
            model(y, ex, ee);
            send(y, x, e);
            check("rand x", x, ex);
            check("rand err", e, ee);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
